pipeline_stall_controller: RTL and testbench

Central stall/flush scheduler for the 5-stage RISC-V pipeline. Sequences the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers for three cases: load-use hazards, taken branches resolved in EX, and multi-cycle data-memory accesses. Outputs are Mealy: they act in the same cycle as the hazard. State, countdowns and timeout are registered.

---
 rtl/pipeline_stall_controller.sv | 203 ++++++++++++++++++++
 tb/tb_pipeline_stall_controller.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_controller.sv
// Purpose : stall/flush scheduler for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
// Latency : Mealy; the enables act in the same cycle as the hazard. State, countdown and timeout are registered.
// Backpr. : a pending data-memory access (mem_req && !mem_ready) freezes the whole front end until mem_ready.
//
// Ports:
//   clk, reset                  clock; synchronous active-high reset (all outputs 0 while asserted)
//   id_rs1, id_rs2              source registers of the instruction in ID
//   ex_rd, ex_memread           destination register / load flag of the instruction in EX
//   ex_branch_taken             branch or jump resolved taken in EX
//   mem_req, mem_ready          EX/MEM data-memory access request / completion
//   pc_write, ifid_write        PC and IF/ID load enables
//   ifid_flush                  IF/ID clear to NOP
//   idex_write, idex_bubble     ID/EX load enable / load zeroed control
//   exmem_hold, memwb_bubble    EX/MEM hold / MEM/WB load zeroed control
//   mem_timeout_err             sticky: memory access exceeded MEM_TIMEOUT cycles
//   stall_cycles, flush_count   statistics, present only with STALL_STATS_EN defined (else tied to 0)
//
// Build option: define STALL_STATS_EN to instantiate the statistics counters.

module pipeline_stall_controller #(
  parameter int LU_STALL_CYCLES = 1,   // bubbles per load-use hazard, 1..7
  parameter int MEM_TIMEOUT     = 15   // max memory wait cycles, 2..255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_memread,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_write,
  output logic        idex_bubble,
  output logic        exmem_hold,
  output logic        memwb_bubble,
  output logic        mem_timeout_err,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_LU_STALL = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;
  localparam logic [1:0] ST_ERR      = 2'd3;

  localparam logic [2:0] LU_RELOAD = 3'(LU_STALL_CYCLES - 1);
  localparam logic [7:0] TMO_LIMIT = 8'(MEM_TIMEOUT);

  logic [1:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] tmo_q, tmo_d;
  logic       err_q, err_d;

  logic       mem_stall;
  logic       load_use;
  logic       fe_eval;     // front end decides via branch/load-use rules this cycle
  logic       freeze;      // full pipeline freeze for a pending memory access
  logic       lu_hold;     // load-use bubble outputs
  logic [7:0] tmo_inc;

  assign mem_stall = mem_req && !mem_ready;
  assign load_use  = ex_memread && (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  assign tmo_inc   = tmo_q + 8'd1;

  // Next-state logic and front-end decision.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    fe_eval = 1'b0;
    freeze  = 1'b0;
    lu_hold = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          freeze  = 1'b1;
          state_d = ST_MEM_WAIT;
          tmo_d   = 8'd1;   // the freeze cycle itself counts as the first wait cycle
        end else begin
          fe_eval = 1'b1;
        end
      end
      ST_LU_STALL: begin
        if (mem_stall) begin
          // The memory freeze outlasts any remaining bubbles, so the countdown is dropped.
          freeze  = 1'b1;
          state_d = ST_MEM_WAIT;
          tmo_d   = 8'd1;
          cnt_d   = 3'd0;
        end else begin
          lu_hold = 1'b1;
          if (cnt_q <= 3'd1) begin
            cnt_d   = 3'd0;
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_ready) begin
          freeze = 1'b1;
          tmo_d  = tmo_inc;
          if (tmo_inc >= TMO_LIMIT) begin
            err_d   = 1'b1;
            state_d = ST_ERR;
          end
        end else begin
          // Release cycle: back end runs again, front end follows the branch/load-use rules.
          tmo_d   = 8'd0;
          state_d = ST_RUN;
          fe_eval = 1'b1;
        end
      end
      default: begin
        freeze = 1'b1;   // ST_ERR: stuck until reset
      end
    endcase

    // A taken branch flushes the ID instruction, so a simultaneous load-use is moot.
    if (fe_eval && !ex_branch_taken && load_use) begin
      lu_hold = 1'b1;
      if (LU_STALL_CYCLES > 1) begin
        state_d = ST_LU_STALL;
        cnt_d   = LU_RELOAD;
      end
    end
  end

  // Output decode; everything is forced low while reset is held.
  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_write   = 1'b1;
    idex_bubble  = 1'b0;
    exmem_hold   = 1'b0;
    memwb_bubble = 1'b0;

    if (reset) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_write = 1'b0;
    end else if (freeze) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_hold   = 1'b1;
      memwb_bubble = 1'b1;
    end else if (fe_eval && ex_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (lu_hold) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  assign mem_timeout_err = err_q & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= 3'd0;
      tmo_q   <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

`ifdef STALL_STATS_EN
  logic [31:0] stall_q;
  logic [15:0] flush_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= 32'd0;
      flush_q <= 16'd0;
    end else begin
      if (!pc_write && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'd1;
      if (ifid_flush && (flush_q != 16'hFFFF))     flush_q <= flush_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = 32'd0;
  assign flush_count  = 16'd0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
module tb_pipeline_stall_controller;

  typedef struct packed {
    logic       reset;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       memread;
    logic       br;
    logic       req;
    logic       rdy;
  } in_t;

  typedef struct packed {
    logic pc_w;
    logic ifid_w;
    logic flush;
    logic idex_w;
    logic bubble;
    logic hold;
    logic mwb;
    logic err;
  } out_t;

  typedef struct {
    in_t   i;
    out_t  o;
    string name;
  } vec_t;

  localparam out_t O_RST = 8'b0000_0000;
  localparam out_t O_DEF = 8'b1101_0000;
  localparam out_t O_LU  = 8'b0001_1000;
  localparam out_t O_BR  = 8'b1111_1000;
  localparam out_t O_FRZ = 8'b0000_0110;
  localparam out_t O_ERR = 8'b0000_0111;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] id_rs1 = 5'd0, id_rs2 = 5'd0, ex_rd = 5'd0;
  logic ex_memread = 1'b0, ex_branch_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;

  logic pc_write0, ifid_write0, ifid_flush0, idex_write0, idex_bubble0, exmem_hold0, memwb_bubble0, err0;
  logic pc_write1, ifid_write1, ifid_flush1, idex_write1, idex_bubble1, exmem_hold1, memwb_bubble1, err1;
  logic [31:0] sc0, sc1;
  logic [15:0] fc0, fc1;

  always #5 clk = ~clk;

  pipeline_stall_controller #(.LU_STALL_CYCLES(1), .MEM_TIMEOUT(15)) u_lu1 (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
    .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write0), .ifid_write(ifid_write0), .ifid_flush(ifid_flush0), .idex_write(idex_write0),
    .idex_bubble(idex_bubble0), .exmem_hold(exmem_hold0), .memwb_bubble(memwb_bubble0),
    .mem_timeout_err(err0), .stall_cycles(sc0), .flush_count(fc0)
  );

  pipeline_stall_controller #(.LU_STALL_CYCLES(3), .MEM_TIMEOUT(15)) u_lu3 (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
    .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write1), .ifid_write(ifid_write1), .ifid_flush(ifid_flush1), .idex_write(idex_write1),
    .idex_bubble(idex_bubble1), .exmem_hold(exmem_hold1), .memwb_bubble(memwb_bubble1),
    .mem_timeout_err(err1), .stall_cycles(sc1), .flush_count(fc1)
  );

  out_t act0, act1;
  assign act0 = {pc_write0, ifid_write0, ifid_flush0, idex_write0, idex_bubble0, exmem_hold0, memwb_bubble0, err0};
  assign act1 = {pc_write1, ifid_write1, ifid_flush1, idex_write1, idex_bubble1, exmem_hold1, memwb_bubble1, err1};

  int total = 0;
  int bad   = 0;
  int sel   = 0;           // 0: checks u_lu1, 1: checks u_lu3
  out_t exp_q[$];          // scoreboard of expected outputs
  logic [31:0] m_stall = 32'd0;
  logic [15:0] m_flush = 16'd0;
  vec_t tbl[$];

  function automatic in_t mk(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic mr, input logic br,
                             input logic rq, input logic ry);
    in_t v;
    v.reset = rst; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.memread = mr; v.br = br; v.req = rq; v.rdy = ry;
    return v;
  endfunction

  function automatic vec_t mkv(input in_t i, input out_t o, input string nm);
    vec_t v;
    v.i = i; v.o = o; v.name = nm;
    return v;
  endfunction

  // Drive one cycle of stimulus, queue its expectation, then check mid-cycle.
  task automatic step(input in_t i, input out_t o, input string nm);
    out_t e, a;
    logic [31:0] sc, esc;
    logic [15:0] fc, efc;
    @(posedge clk);
    #1;
    reset = i.reset; id_rs1 = i.rs1; id_rs2 = i.rs2; ex_rd = i.rd;
    ex_memread = i.memread; ex_branch_taken = i.br; mem_req = i.req; mem_ready = i.rdy;
    exp_q.push_back(o);
    @(negedge clk);
    e = exp_q.pop_front();
    a = (sel != 0) ? act1 : act0;
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: outputs got %b want %b (pc,ifw,flush,idw,bub,hold,mwb,err)", nm, a, e);
    end
    if (!i.reset) begin
      sc = (sel != 0) ? sc1 : sc0;
      fc = (sel != 0) ? fc1 : fc0;
`ifdef STALL_STATS_EN
      esc = m_stall; efc = m_flush;
`else
      esc = 32'd0; efc = 16'd0;
`endif
      total++;
      if (sc !== esc || fc !== efc) begin
        bad++;
        $display("FAIL %s_stats: stall=%0d flush=%0d want stall=%0d flush=%0d", nm, sc, fc, esc, efc);
      end
    end
    if (i.reset) begin
      m_stall = 32'd0;
      m_flush = 16'd0;
    end else begin
      if (!e.pc_w && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
      if (e.flush && m_flush != 16'hFFFF) m_flush = m_flush + 16'd1;
    end
  endtask

  initial begin
    in_t idle, rst, lu, frz, rel;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0);
    rst  = mk(1, 0, 0, 0, 0, 0, 0, 0);
    lu   = mk(0, 0, 5, 5, 1, 0, 0, 0);
    frz  = mk(0, 0, 0, 0, 0, 0, 1, 0);
    rel  = mk(0, 0, 0, 0, 0, 0, 1, 1);

    tbl.push_back(mkv(rst,                         O_RST, "reset"));
    tbl.push_back(mkv(idle,                        O_DEF, "idle"));
    tbl.push_back(mkv(mk(0, 3, 5, 5, 1, 0, 0, 0),  O_LU,  "lu_rs2"));
    tbl.push_back(mkv(idle,                        O_DEF, "lu_one_cycle"));
    tbl.push_back(mkv(mk(0, 0, 0, 0, 1, 0, 0, 0),  O_DEF, "lu_rd0"));
    tbl.push_back(mkv(mk(0, 7, 2, 7, 1, 0, 0, 0),  O_LU,  "lu_rs1"));
    tbl.push_back(mkv(mk(0, 7, 7, 7, 0, 0, 0, 0),  O_DEF, "no_load"));
    tbl.push_back(mkv(mk(0, 4, 9, 9, 1, 1, 0, 0),  O_BR,  "br_over_lu"));
    tbl.push_back(mkv(rel,                         O_DEF, "single_cycle_mem"));
    tbl.push_back(mkv(mk(0, 0, 0, 0, 0, 0, 0, 1),  O_DEF, "ready_no_req"));
    tbl.push_back(mkv(mk(0, 0, 0, 0, 0, 1, 0, 0),  O_BR,  "branch"));
    tbl.push_back(mkv(mk(0, 1, 2, 3, 1, 0, 0, 0),  O_DEF, "lu_no_match"));
    tbl.push_back(mkv(idle,                        O_DEF, "settle"));

    sel = 0;
    foreach (tbl[k]) step(tbl[k].i, tbl[k].o, tbl[k].name);

    // Multi-cycle load-use bubbles; inputs during the stall are ignored.
    sel = 1;
    step(rst, O_RST, "lu3_reset");
    for (int k = 0; k < 3; k++) step(idle, O_DEF, "lu3_idle");
    step(lu, O_LU, "lu3_c10");
    step(mk(0, 0, 0, 0, 0, 1, 0, 0), O_LU, "lu3_c11_br_ignored");
    step(idle, O_LU, "lu3_c12");
    step(idle, O_DEF, "lu3_c13");
    step(idle, O_DEF, "lu3_c14");

    // Memory freeze preempts the countdown, which is discarded.
    step(rst, O_RST, "pre_reset");
    step(lu, O_LU, "pre_lu");
    step(frz, O_FRZ, "pre_freeze");
    step(rel, O_DEF, "pre_release");
    step(idle, O_DEF, "pre_no_resume");

    // Load-use taken in the release cycle starts a fresh stall.
    step(rst, O_RST, "rel_lu_reset");
    step(frz, O_FRZ, "rel_lu_frz0");
    step(frz, O_FRZ, "rel_lu_frz1");
    step(mk(0, 0, 5, 5, 1, 0, 1, 1), O_LU, "rel_lu_release");
    step(idle, O_LU, "rel_lu_s1");
    step(idle, O_LU, "rel_lu_s2");
    step(idle, O_DEF, "rel_lu_done");

    // Memory wait of four cycles, then release; branch in a later release.
    sel = 0;
    step(rst, O_RST, "mw_reset");
    for (int k = 0; k < 4; k++) step(frz, O_FRZ, "mw_wait");
    step(rel, O_DEF, "mw_release");
    step(idle, O_DEF, "mw_stats");
    step(frz, O_FRZ, "mw_br_wait");
    step(mk(0, 0, 5, 5, 1, 1, 1, 1), O_BR, "mw_br_release");
    step(idle, O_DEF, "mw_br_stats");

    // Timeout: fifteen frozen cycles, then sticky error until reset.
    step(rst, O_RST, "tmo_reset");
    for (int k = 0; k < 15; k++) step(frz, O_FRZ, "tmo_wait");
    step(frz, O_ERR, "tmo_err");
    step(rel, O_ERR, "tmo_err_ready_ignored");
    step(mk(0, 0, 0, 0, 0, 1, 1, 1), O_ERR, "tmo_err_br_ignored");
    step(rst, O_RST, "tmo_clear");
    step(idle, O_DEF, "tmo_run");

    // Reset in the middle of a memory wait.
    step(rst, O_RST, "mid_reset0");
    step(frz, O_FRZ, "mid_frz");
    step(frz, O_FRZ, "mid_wait1");
    step(mk(1, 0, 0, 0, 0, 0, 1, 0), O_RST, "mid_wait2_reset");
    step(idle, O_DEF, "mid_run");
    step(idle, O_DEF, "mid_run2");
    step(rel, O_DEF, "mid_single_access");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
